// File: rtl/mips_multicycle_control_pkg.sv
// Shared encodings for the multicycle MIPS main control FSM and its ALU control consumer.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_ADDIEX = 4'd9,
        S_ANDIEX = 4'd10,
        S_IMMWB  = 4'd11,
        S_JUMP   = 4'd12
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_J     = 6'h02;

    localparam logic [1:0] ALUOP_ADD     = 2'b00;
    localparam logic [1:0] ALUOP_SUB     = 2'b01;
    localparam logic [1:0] ALUOP_RFORMAT = 2'b10;
    localparam logic [1:0] ALUOP_AND     = 2'b11;

    localparam logic [1:0] SRCB_RT     = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMMSH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;
    localparam logic [1:0] PCSRC_RS     = 2'b11;

endpackage

// File: rtl/mips_multicycle_control_if.sv
// Control-to-datapath bundle: opcode/jr/mem_ready in, enables and mux selects out.
// Memory handshake: memread/memwrite act as valid and stay high until the cycle mem_ready=1 completes the access.
interface mips_ctrl_if #(parameter int STATE_W = 4);
    logic [5:0]         op;
    logic               jr;
    logic               mem_ready;
    logic [1:0]         aluop;
    logic               alusrca;
    logic [1:0]         alusrcb;
    logic [1:0]         pcsrc;
    logic               pcwrite;
    logic               branch;
    logic               iord;
    logic               memread;
    logic               memwrite;
    logic               irwrite;
    logic               memtoreg;
    logic               regdst;
    logic               regwrite;
    logic               illegal_op;
    logic [STATE_W-1:0] state_dbg;

    modport master (
        input  op, jr, mem_ready,
        output aluop, alusrca, alusrcb, pcsrc, pcwrite, branch, iord, memread,
               memwrite, irwrite, memtoreg, regdst, regwrite, illegal_op, state_dbg
    );

    modport slave (
        output op, jr, mem_ready,
        input  aluop, alusrca, alusrcb, pcsrc, pcwrite, branch, iord, memread,
               memwrite, irwrite, memtoreg, regdst, regwrite, illegal_op, state_dbg
    );
endinterface

// File: rtl/mips_multicycle_control.sv
// Main control FSM of the multicycle MIPS core; state is the only register, outputs decode from it.
module mips_multicycle_control
    import mips_ctrl_pkg::*;
#(
    parameter int STATE_W = 4
) (
    input  logic          clk,
    input  logic          reset_n,
    mips_ctrl_if.master   ctrl
);

    state_e state_q, state_d;

    always_ff @(posedge clk) begin
        if (!reset_n) state_q <= S_FETCH;
        else          state_q <= state_d;
    end

    assign ctrl.state_dbg = reset_n ? STATE_W'(state_q) : STATE_W'(S_FETCH);

    always_comb begin
        state_d         = S_FETCH;
        ctrl.aluop      = ALUOP_ADD;
        ctrl.alusrca    = 1'b0;
        ctrl.alusrcb    = SRCB_RT;
        ctrl.pcsrc      = PCSRC_ALU;
        ctrl.pcwrite    = 1'b0;
        ctrl.branch     = 1'b0;
        ctrl.iord       = 1'b0;
        ctrl.memread    = 1'b0;
        ctrl.memwrite   = 1'b0;
        ctrl.irwrite    = 1'b0;
        ctrl.memtoreg   = 1'b0;
        ctrl.regdst     = 1'b0;
        ctrl.regwrite   = 1'b0;
        ctrl.illegal_op = 1'b0;

        case (state_q)
            S_FETCH: begin
                ctrl.memread = 1'b1;
                ctrl.alusrcb = SRCB_FOUR;
                if (ctrl.mem_ready) begin
                    ctrl.irwrite = 1'b1;
                    ctrl.pcwrite = 1'b1;
                    state_d      = S_DECODE;
                end else begin
                    state_d      = S_FETCH;
                end
            end
            S_DECODE: begin
                // Branch target is precomputed here so BRANCH only needs the compare.
                ctrl.alusrcb = SRCB_IMMSH2;
                case (ctrl.op)
                    OP_RTYPE:     state_d = S_EXEC;
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_ANDI:      state_d = S_ANDIEX;
                    OP_J:         state_d = S_JUMP;
                    default:      ctrl.illegal_op = 1'b1;
                endcase
            end
            S_MEMADR: begin
                ctrl.alusrca = 1'b1;
                ctrl.alusrcb = SRCB_IMM;
                state_d      = (ctrl.op == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                ctrl.memread = 1'b1;
                ctrl.iord    = 1'b1;
                state_d      = ctrl.mem_ready ? S_MEMWB : S_MEMRD;
            end
            S_MEMWB: begin
                ctrl.regwrite = 1'b1;
                ctrl.memtoreg = 1'b1;
            end
            S_MEMWR: begin
                ctrl.memwrite = 1'b1;
                ctrl.iord     = 1'b1;
                state_d       = ctrl.mem_ready ? S_FETCH : S_MEMWR;
            end
            S_EXEC: begin
                ctrl.alusrca = 1'b1;
                ctrl.aluop   = ALUOP_RFORMAT;
                if (ctrl.jr) begin
                    ctrl.pcwrite = 1'b1;
                    ctrl.pcsrc   = PCSRC_RS;
                end else begin
                    state_d      = S_ALUWB;
                end
            end
            S_ALUWB: begin
                ctrl.regwrite = 1'b1;
                ctrl.regdst   = 1'b1;
            end
            S_BRANCH: begin
                ctrl.alusrca = 1'b1;
                ctrl.aluop   = ALUOP_SUB;
                ctrl.branch  = 1'b1;
                ctrl.pcsrc   = PCSRC_ALUOUT;
            end
            S_ADDIEX: begin
                ctrl.alusrca = 1'b1;
                ctrl.alusrcb = SRCB_IMM;
                state_d      = S_IMMWB;
            end
            S_ANDIEX: begin
                ctrl.alusrca = 1'b1;
                ctrl.alusrcb = SRCB_IMM;
                ctrl.aluop   = ALUOP_AND;
                state_d      = S_IMMWB;
            end
            S_IMMWB: begin
                ctrl.regwrite = 1'b1;
            end
            S_JUMP: begin
                ctrl.pcwrite = 1'b1;
                ctrl.pcsrc   = PCSRC_JUMP;
            end
            default: state_d = S_FETCH;
        endcase

        // Reset abandons any in-flight access: every enable and select goes low at once.
        if (!reset_n) begin
            ctrl.aluop      = ALUOP_ADD;
            ctrl.alusrca    = 1'b0;
            ctrl.alusrcb    = SRCB_RT;
            ctrl.pcsrc      = PCSRC_ALU;
            ctrl.pcwrite    = 1'b0;
            ctrl.branch     = 1'b0;
            ctrl.iord       = 1'b0;
            ctrl.memread    = 1'b0;
            ctrl.memwrite   = 1'b0;
            ctrl.irwrite    = 1'b0;
            ctrl.memtoreg   = 1'b0;
            ctrl.regdst     = 1'b0;
            ctrl.regwrite   = 1'b0;
            ctrl.illegal_op = 1'b0;
        end
    end

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Self-checking bench for mips_multicycle_control: per-cycle expected state/outputs queued by the driver, compared at negedge.
module tb_mips_multicycle_control;
    import mips_ctrl_pkg::*;

    typedef struct packed {
        logic [3:0] st;
        logic [1:0] aluop;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] pcsrc;
        logic       pcwrite;
        logic       branch;
        logic       iord;
        logic       memread;
        logic       memwrite;
        logic       irwrite;
        logic       memtoreg;
        logic       regdst;
        logic       regwrite;
        logic       illegal;
    } obs_t;

    localparam int W = $bits(obs_t);

    logic clk;
    logic reset_n;
    mips_ctrl_if bus ();

    logic [W-1:0] exp_q[$];
    string        tag_q[$];
    int           n_checks;
    int           n_errors;

    mips_multicycle_control #(.STATE_W(4)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .ctrl    (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Expected outputs per state, written from the state table.
    function automatic obs_t spec_out(input state_e st, input logic mr, input logic jrv, input logic ill);
        obs_t e;
        e    = '0;
        e.st = st;
        case (st)
            S_FETCH: begin
                e.memread = 1'b1; e.alusrcb = 2'b01;
                if (mr) begin e.irwrite = 1'b1; e.pcwrite = 1'b1; end
            end
            S_DECODE: begin e.alusrcb = 2'b11; e.illegal = ill; end
            S_MEMADR: begin e.alusrca = 1'b1; e.alusrcb = 2'b10; end
            S_MEMRD:  begin e.memread = 1'b1; e.iord = 1'b1; end
            S_MEMWB:  begin e.regwrite = 1'b1; e.memtoreg = 1'b1; end
            S_MEMWR:  begin e.memwrite = 1'b1; e.iord = 1'b1; end
            S_EXEC: begin
                e.alusrca = 1'b1; e.aluop = 2'b10;
                if (jrv) begin e.pcwrite = 1'b1; e.pcsrc = 2'b11; end
            end
            S_ALUWB:  begin e.regwrite = 1'b1; e.regdst = 1'b1; end
            S_BRANCH: begin e.alusrca = 1'b1; e.aluop = 2'b01; e.branch = 1'b1; e.pcsrc = 2'b01; end
            S_ADDIEX: begin e.alusrca = 1'b1; e.alusrcb = 2'b10; end
            S_ANDIEX: begin e.alusrca = 1'b1; e.alusrcb = 2'b10; e.aluop = 2'b11; end
            S_IMMWB:  begin e.regwrite = 1'b1; end
            S_JUMP:   begin e.pcwrite = 1'b1; e.pcsrc = 2'b10; end
            default:  e = '0;
        endcase
        return e;
    endfunction

    function automatic logic rnd_bit();
        return 1'($urandom_range(0, 1));
    endfunction

    // One clock of stimulus; its expected observation is queued for the monitor.
    task automatic drive(input state_e st, input logic [5:0] op_v, input logic jr_v,
                         input logic mr_v, input logic rst_v, input logic ill);
        obs_t e;
        bus.op        = op_v;
        bus.jr        = jr_v;
        bus.mem_ready = mr_v;
        reset_n       = rst_v;
        if (rst_v) e = spec_out(st, mr_v, jr_v, ill);
        else begin e = '0; e.st = S_FETCH; end
        exp_q.push_back(e);
        tag_q.push_back(rst_v ? st.name() : "RESET");
        @(posedge clk);
        #1;
    endtask

    task automatic run_instr(input logic [5:0] op_v, input logic jr_v, input int fstall, input int mstall);
        logic legal;
        legal = (op_v == 6'h00) || (op_v == 6'h23) || (op_v == 6'h2B) || (op_v == 6'h04) ||
                (op_v == 6'h08) || (op_v == 6'h0C) || (op_v == 6'h02);
        for (int i = 0; i < fstall; i++) drive(S_FETCH, op_v, rnd_bit(), 1'b0, 1'b1, 1'b0);
        drive(S_FETCH, op_v, rnd_bit(), 1'b1, 1'b1, 1'b0);
        drive(S_DECODE, op_v, rnd_bit(), rnd_bit(), 1'b1, !legal);
        case (op_v)
            6'h00: begin
                drive(S_EXEC, op_v, jr_v, rnd_bit(), 1'b1, 1'b0);
                if (!jr_v) drive(S_ALUWB, op_v, rnd_bit(), rnd_bit(), 1'b1, 1'b0);
            end
            6'h23: begin
                drive(S_MEMADR, op_v, rnd_bit(), rnd_bit(), 1'b1, 1'b0);
                for (int i = 0; i < mstall; i++) drive(S_MEMRD, op_v, rnd_bit(), 1'b0, 1'b1, 1'b0);
                drive(S_MEMRD, op_v, rnd_bit(), 1'b1, 1'b1, 1'b0);
                drive(S_MEMWB, op_v, rnd_bit(), rnd_bit(), 1'b1, 1'b0);
            end
            6'h2B: begin
                drive(S_MEMADR, op_v, rnd_bit(), rnd_bit(), 1'b1, 1'b0);
                for (int i = 0; i < mstall; i++) drive(S_MEMWR, op_v, rnd_bit(), 1'b0, 1'b1, 1'b0);
                drive(S_MEMWR, op_v, rnd_bit(), 1'b1, 1'b1, 1'b0);
            end
            6'h04: drive(S_BRANCH, op_v, rnd_bit(), rnd_bit(), 1'b1, 1'b0);
            6'h08: begin
                drive(S_ADDIEX, op_v, rnd_bit(), rnd_bit(), 1'b1, 1'b0);
                drive(S_IMMWB, op_v, rnd_bit(), rnd_bit(), 1'b1, 1'b0);
            end
            6'h0C: begin
                drive(S_ANDIEX, op_v, rnd_bit(), rnd_bit(), 1'b1, 1'b0);
                drive(S_IMMWB, op_v, rnd_bit(), rnd_bit(), 1'b1, 1'b0);
            end
            6'h02: drive(S_JUMP, op_v, rnd_bit(), rnd_bit(), 1'b1, 1'b0);
            default: ;
        endcase
    endtask

    always @(negedge clk) begin
        obs_t got;
        string tag;
        got = '{st: bus.state_dbg, aluop: bus.aluop, alusrca: bus.alusrca, alusrcb: bus.alusrcb,
                pcsrc: bus.pcsrc, pcwrite: bus.pcwrite, branch: bus.branch, iord: bus.iord,
                memread: bus.memread, memwrite: bus.memwrite, irwrite: bus.irwrite,
                memtoreg: bus.memtoreg, regdst: bus.regdst, regwrite: bus.regwrite,
                illegal: bus.illegal_op};
        if (exp_q.size() != 0) begin
            tag = tag_q.pop_front();
            check(tag, got, exp_q.pop_front());
            check("mem_excl", W'(bus.memread & bus.memwrite), '0);
            check("pc_excl", W'(bus.pcwrite & bus.branch), '0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [5:0] op_tab [8];
        logic [5:0] rop;
        n_checks      = 0;
        n_errors      = 0;
        reset_n       = 1'b0;
        bus.op        = 6'h00;
        bus.jr        = 1'b0;
        bus.mem_ready = 1'b1;
        op_tab = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h08, 6'h0C, 6'h02, 6'h3F};
        @(posedge clk);
        #1;

        drive(S_FETCH, 6'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        drive(S_FETCH, 6'h23, 1'b1, 1'b1, 1'b0, 1'b0);

        run_instr(OP_RTYPE, 1'b0, 0, 0);
        run_instr(OP_LW, 1'b0, 0, 3);
        run_instr(OP_RTYPE, 1'b1, 0, 0);
        run_instr(OP_BEQ, 1'b0, 0, 0);
        run_instr(OP_ANDI, 1'b0, 0, 0);
        run_instr(6'h3F, 1'b0, 0, 0);
        run_instr(OP_ADDI, 1'b0, 1, 0);
        run_instr(OP_J, 1'b0, 0, 0);
        run_instr(OP_SW, 1'b0, 0, 2);
        run_instr(OP_LW, 1'b0, 2, 0);

        // Reset lands while a store is waiting on memory.
        drive(S_FETCH, OP_SW, 1'b0, 1'b1, 1'b1, 1'b0);
        drive(S_DECODE, OP_SW, 1'b0, 1'b0, 1'b1, 1'b0);
        drive(S_MEMADR, OP_SW, 1'b0, 1'b0, 1'b1, 1'b0);
        drive(S_MEMWR, OP_SW, 1'b0, 1'b0, 1'b1, 1'b0);
        drive(S_MEMWR, OP_SW, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(S_FETCH, OP_SW, 1'b0, 1'b0, 1'b1, 1'b0);
        run_instr(OP_RTYPE, 1'b0, 0, 0);

        for (int n = 0; n < 40; n++) begin
            rop = op_tab[$urandom_range(0, 7)];
            if (rop == 6'h3F) rop = 6'($urandom_range(0, 63));
            run_instr(rop, rnd_bit(), $urandom_range(0, 2), $urandom_range(0, 2));
        end

        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
        if (exp_q.size() != 0) check("drain", W'(exp_q.size()), '0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
